// File: rtl/fork_pkg.sv
// Shared types and sizing helpers for the clocked 3-way fork controller.
package fork_pkg;

  localparam int unsigned NUM_BRANCH  = 3;
  localparam int unsigned SETUP_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO,
    ERR
  } state_e;

  // Width able to hold 0..t; a disabled timeout (t == 0) still gets one bit.
  function automatic int unsigned tmo_cnt_w(input int unsigned t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/ack_sync.sv
// Multi-flop synchronizer for one asynchronous acknowledge, synchronous reset to 0.
module ack_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/fork3_sync.sv
// Clocked 3-way fork: accepts a valid/ready token, holds data_o, runs a 4-phase
// req/ack handshake on each enabled asynchronous branch and joins the acks.
module fork3_sync
  import fork_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  input  logic [2:0]    mask_i,
  output logic [DW-1:0] data_o,
  output logic          req_out1_o,
  output logic          req_out2_o,
  output logic          req_out3_o,
  input  logic          ack_out1_i,
  input  logic          ack_out2_i,
  input  logic          ack_out3_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o
);

  localparam int unsigned TMO_W     = tmo_cnt_w(TIMEOUT_CYC);
  localparam int unsigned TMO_LIMIT = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam int unsigned PRIME_W   = $clog2(SYNC_STAGES + 1);

  state_e                 state_q, state_d;
  logic [SETUP_CNT_W-1:0] setup_cnt_q, setup_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic [PRIME_W-1:0]     prime_cnt_q, prime_cnt_d;
  logic [DW-1:0]          data_q, data_d;
  logic [NUM_BRANCH-1:0]  en_q, en_d;
  logic [NUM_BRANCH-1:0]  req_q, req_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic [NUM_BRANCH-1:0]  ack_async;
  logic [NUM_BRANCH-1:0]  ack_s;
  logic                   all_hi, all_lo;
  logic                   primed;
  logic                   tmo_hit;
  logic [TMO_W-1:0]       tmo_inc;
  logic                   accept;

  assign ack_async = {ack_out3_i, ack_out2_i, ack_out1_i};

  for (genvar k = 0; k < NUM_BRANCH; k++) begin : g_ack_sync
    ack_sync #(
      .STAGES (SYNC_STAGES)
    ) u_ack_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (ack_async[k]),
      .sync_o  (ack_s[k])
    );
  end

  assign all_hi = &(ack_s | ~en_q);
  assign all_lo = ~|(ack_s & en_q);

  // Synchronizers read 0 right after reset even if acks are still high, so
  // acceptance waits until the chain has refilled with real ack levels.
  assign primed = (prime_cnt_q == PRIME_W'(SYNC_STAGES));

  assign ready_o = !rst_i && primed && (state_q == IDLE) && (ack_s == '0);
  assign accept  = valid_i && ready_o;

  assign tmo_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_W'(TMO_LIMIT));
  assign tmo_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    prime_cnt_d = primed ? prime_cnt_q : prime_cnt_q + 1'b1;
    data_d      = data_q;
    en_d        = en_q;
    req_d       = req_q;
    done_d      = 1'b0;
    error_d     = error_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = data_i;
          en_d   = mask_i;
          if (mask_i != '0) begin
            state_d     = SETUP;
            setup_cnt_d = '0;
            tmo_cnt_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (setup_cnt_q == SETUP_CNT_W'(SETUP_CYC)) begin
          state_d = REQ_HI;
          req_d   = en_q;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      REQ_HI: begin
        // Acks dropping early are ignored: all_hi is a level test only.
        if (all_hi) begin
          state_d   = REQ_LO;
          req_d     = '0;
          tmo_cnt_d = '0;
        end else if (tmo_hit) begin
          state_d = ERR;
          req_d   = '0;
          error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
      REQ_LO: begin
        if (all_lo) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d = ERR;
          req_d   = '0;
          error_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
      ERR: begin
        req_d   = '0;
        error_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      prime_cnt_q <= '0;
      data_q      <= '0;
      en_q        <= '0;
      req_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      prime_cnt_q <= prime_cnt_d;
      data_q      <= data_d;
      en_q        <= en_d;
      req_q       <= req_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign data_o     = data_q;
  assign req_out1_o = req_q[0];
  assign req_out2_o = req_q[1];
  assign req_out3_o = req_q[2];
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_fork3_sync.sv
// Directed bench for fork3_sync: main instance plus a short-timeout instance.
module tb_fork3_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] data;
  logic [2:0]  mask;
  logic [2:0]  ack;
  logic        ready, busy, done, error;
  logic [31:0] data_o;
  logic        req1, req2, req3;
  logic [2:0]  req;

  logic        t_valid;
  logic [31:0] t_data;
  logic [2:0]  t_mask;
  logic [2:0]  t_ack;
  logic        t_ready, t_busy, t_done, t_error;
  logic [31:0] t_data_o;
  logic        t_req1, t_req2, t_req3;
  logic [2:0]  t_req;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign req   = {req3, req2, req1};
  assign t_req = {t_req3, t_req2, t_req1};

  fork3_sync #(
    .DW          (32),
    .SETUP_CYC   (1),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (1024)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .ready_o    (ready),
    .data_i     (data),
    .mask_i     (mask),
    .data_o     (data_o),
    .req_out1_o (req1),
    .req_out2_o (req2),
    .req_out3_o (req3),
    .ack_out1_i (ack[0]),
    .ack_out2_i (ack[1]),
    .ack_out3_i (ack[2]),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error)
  );

  fork3_sync #(
    .DW          (32),
    .SETUP_CYC   (1),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (16)
  ) u_tmo (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (t_valid),
    .ready_o    (t_ready),
    .data_i     (t_data),
    .mask_i     (t_mask),
    .data_o     (t_data_o),
    .req_out1_o (t_req1),
    .req_out2_o (t_req2),
    .req_out3_o (t_req3),
    .ack_out1_i (t_ack[0]),
    .ack_out2_i (t_ack[1]),
    .ack_out3_i (t_ack[2]),
    .busy_o     (t_busy),
    .done_o     (t_done),
    .error_o    (t_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int dones;
    int tok;
    logic acc;

    rst = 1'b1; valid = 1'b0; data = '0; mask = '0; ack = '0;
    t_valid = 1'b0; t_data = '0; t_mask = '0; t_ack = '0;

    // Reset state
    tick(3);
    chk("rst_ready", ready, 1'b0);
    chk("rst_req", req, 3'b000);
    chk("rst_data", data_o, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    rst = 1'b0;
    tick(3);
    chk("idle_ready", ready, 1'b1);

    // Basic: accept at edge 0, reqs at 2, acks at 5 -> reqs drop at 8,
    // acks drop at 10 -> done at 13.
    valid = 1'b1; data = 32'hA5A5_0001; mask = 3'b111;
    tick(1);
    valid = 1'b0; data = 32'hDEAD_BEEF;
    chk("basic_busy", busy, 1'b1);
    chk("basic_data_e0", data_o, 32'hA5A5_0001);
    chk("basic_ready_e0", ready, 1'b0);
    tick(1);
    chk("basic_req_c1", req, 3'b000);
    tick(1);
    chk("basic_req_c2", req, 3'b111);
    tick(3);
    ack = 3'b111;
    tick(2);
    chk("basic_req_c7", req, 3'b111);
    tick(1);
    chk("basic_req_c8", req, 3'b000);
    chk("basic_data_c8", data_o, 32'hA5A5_0001);
    tick(2);
    ack = 3'b000;
    tick(2);
    chk("basic_done_c12", done, 1'b0);
    chk("basic_busy_c12", busy, 1'b1);
    tick(1);
    chk("basic_done_c13", done, 1'b1);
    chk("basic_idle_c13", busy, 1'b0);
    chk("basic_data_c13", data_o, 32'hA5A5_0001);
    tick(1);
    chk("basic_done_c14", done, 1'b0);

    // Skewed acks relative to req rise R: ack2 +3, ack3 +7, ack1 +20.
    valid = 1'b1; data = 32'h0000_0002; mask = 3'b111;
    tick(1);
    valid = 1'b0;
    tick(2);
    chk("skew_req_r", req, 3'b111);
    for (int i = 1; i <= 23; i++) begin
      tick(1);
      if (i == 3) ack[1] = 1'b1;
      if (i == 7) ack[2] = 1'b1;
      if (i == 20) ack[0] = 1'b1;
      if (i == 22) chk("skew_req_hold", req, 3'b111);
      if (i == 23) chk("skew_req_fall", req, 3'b000);
    end
    ack = 3'b000;
    tick(3);
    chk("skew_done", done, 1'b1);

    // Mask 010: only branch 2 handshakes; branches 1 and 3 stay silent.
    valid = 1'b1; data = 32'h0000_0003; mask = 3'b010;
    tick(1);
    valid = 1'b0;
    tick(2);
    chk("m010_req", req, 3'b010);
    ack = 3'b010;
    tick(3);
    chk("m010_req_fall", req, 3'b000);
    ack = 3'b000;
    tick(3);
    chk("m010_done", done, 1'b1);

    // Mask 000: immediate done, no request activity.
    valid = 1'b1; data = 32'h0000_0004; mask = 3'b000;
    tick(1);
    valid = 1'b0;
    chk("m000_done", done, 1'b1);
    chk("m000_busy", busy, 1'b0);
    chk("m000_data", data_o, 32'h0000_0004);
    tick(1);
    chk("m000_done_end", done, 1'b0);
    chk("m000_req", req, 3'b000);

    // Back-to-back: four tokens with valid held high, acks mirror reqs.
    tok = 1; data = 32'd1; mask = 3'b111; valid = 1'b1; dones = 0;
    for (int cyc = 0; cyc < 300 && dones < 4; cyc++) begin
      acc = valid && ready;
      ack = req;
      tick(1);
      if (acc) begin
        tok++;
        data = 32'(tok);
        valid = (tok <= 4);
      end
      if (done) begin
        chk("b2b_data_at_done", data_o, 64'(dones + 1));
        dones++;
      end
    end
    valid = 1'b0; ack = 3'b000;
    chk("b2b_done_count", 64'(dones), 64'd4);
    chk("b2b_last_data", data_o, 32'd4);

    // Timeout (16 cycles) on the second instance: ack3 never arrives.
    t_valid = 1'b1; t_data = 32'h0000_0007; t_mask = 3'b111;
    tick(1);
    t_valid = 1'b0;
    tick(2);
    chk("tmo_req_r", t_req, 3'b111);
    t_ack = 3'b011;
    tick(15);
    chk("tmo_req_r15", t_req, 3'b111);
    chk("tmo_err_r15", t_error, 1'b0);
    tick(1);
    chk("tmo_req_r16", t_req, 3'b000);
    chk("tmo_err_r16", t_error, 1'b1);
    chk("tmo_ready_r16", t_ready, 1'b0);
    chk("tmo_busy_r16", t_busy, 1'b1);
    t_ack = 3'b000;
    tick(10);
    chk("tmo_err_sticky", t_error, 1'b1);
    chk("tmo_ready_sticky", t_ready, 1'b0);

    // Reset during REQ_HI with acks high; also clears the timed-out instance.
    valid = 1'b1; data = 32'h0000_0005; mask = 3'b111;
    tick(1);
    valid = 1'b0;
    tick(2);
    chk("mrst_req_r", req, 3'b111);
    ack = 3'b111;
    rst = 1'b1;
    tick(1);
    chk("mrst_req", req, 3'b000);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_tmo_err", t_error, 1'b0);
    rst = 1'b0;
    tick(5);
    chk("mrst_ready_blocked", ready, 1'b0);
    ack = 3'b000;
    tick(1);
    chk("mrst_ready_c1", ready, 1'b0);
    tick(1);
    chk("mrst_ready_c2", ready, 1'b1);
    valid = 1'b1; data = 32'h0000_0006; mask = 3'b001;
    tick(1);
    valid = 1'b0;
    chk("mrst_new_data", data_o, 32'h0000_0006);
    chk("mrst_new_busy", busy, 1'b1);
    tick(2);
    chk("mrst_new_req", req, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
